// File: rtl/vga_dual_view_if.sv
// Memory and video bundle of the dual-view VGA controller.
// The master side is the controller, the slave side the memories and the DAC.
interface vga_dual_view_if #(
  parameter int ADDR_W = 18
);
  logic [ADDR_W-1:0] rom_addr;
  logic [23:0]       rom_data;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_data;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              hsync;
  logic              vsync;
  logic              n_blank;
  logic              frame_start;
  logic [1:0]        mode;

  modport master (
    output rom_addr, dmem_addr, red, green, blue, hsync, vsync, n_blank,
           frame_start, mode,
    input  rom_data, dmem_data
  );

  modport slave (
    input  rom_addr, dmem_addr, red, green, blue, hsync, vsync, n_blank,
           frame_start, mode,
    output rom_data, dmem_data
  );
endinterface

// File: rtl/vga_dual_view.sv
// Parametrised VGA controller showing the original ROM image, the processed
// dmem image, or both side by side. Video is delayed to match memory latency.
module vga_dual_view #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          IMG_W    = 256,
  parameter int          IMG_H    = 256,
  parameter int          X0       = 32,
  parameter int          Y0       = 112,
  parameter int          GAP      = 64,
  parameter int          ADDR_W   = 18,
  parameter int          MEM_LAT  = 2,
  parameter logic [23:0] BG_RGB   = 24'h202020
) (
  input  logic            clock_25,
  input  logic            reset,
  input  logic            boton_cursor,
  vga_dual_view_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int X1      = X0 + IMG_W + GAP;

  typedef enum logic [1:0] {
    SRC_BG   = 2'd0,
    SRC_ROM  = 2'd1,
    SRC_DMEM = 2'd2
  } src_e;

  typedef enum logic [1:0] {
    MODE_ORIG = 2'd0,
    MODE_PROC = 2'd1,
    MODE_SIDE = 2'd2
  } mode_e;

  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
    src_e src;
  } vid_t;

  localparam vid_t VID_IDLE = '{hs: 1'b1, vs: 1'b1, act: 1'b0, src: SRC_BG};

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_ORIG: return MODE_PROC;
      MODE_PROC: return MODE_SIDE;
      default:   return MODE_ORIG;
    endcase
  endfunction

  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount;
  int                hx;
  int                vy;
  logic              h_last;
  logic              v_last;
  logic              y_in;
  logic              in_img0;
  logic              in_img1;
  logic [31:0]       addr0;
  logic [31:0]       addr1;
  logic [ADDR_W-1:0] rom_addr_c;
  logic [ADDR_W-1:0] dmem_addr_c;
  logic [ADDR_W-1:0] rom_hold;
  logic [ADDR_W-1:0] dmem_hold;
  vid_t              cur;
  vid_t              dly [MEM_LAT];
  vid_t              last;
  mode_e             mode_q;
  mode_e             pending_mode;
  logic              btn_s1;
  logic              btn_s2;
  logic              btn_d;
  logic              frame_start_q;
  logic              hsync_q;
  logic              vsync_q;
  logic              n_blank_q;
  logic [23:0]       rgb_q;

  assign hx     = 32'(hcount);
  assign vy     = 32'(vcount);
  assign h_last = (hx == H_TOTAL - 1);
  assign v_last = (vy == V_TOTAL - 1);

  assign y_in    = (vy >= Y0) && (vy < Y0 + IMG_H);
  assign in_img0 = y_in && (hx >= X0) && (hx < X0 + IMG_W);
  assign in_img1 = y_in && (hx >= X1) && (hx < X1 + IMG_W) && (mode_q == MODE_SIDE);
  assign addr0   = 32'((vy - Y0) * IMG_W + (hx - X0));
  assign addr1   = 32'((vy - Y0) * IMG_W + (hx - X1));

  // Free-running pixel and line counters.
  always_ff @(posedge clock_25) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (h_last) begin
      hcount <= '0;
      vcount <= v_last ? '0 : vcount + VW'(1);
    end else begin
      hcount <= hcount + HW'(1);
    end
  end

  // Stage 0: raw timing, source tag and memory addresses from the counters.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a latch behind.
    rom_addr_c  = rom_hold;
    dmem_addr_c = dmem_hold;
    cur.hs      = !((hx >= H_ACTIVE + H_FP) && (hx < H_ACTIVE + H_FP + H_SYNC));
    cur.vs      = !((vy >= V_ACTIVE + V_FP) && (vy < V_ACTIVE + V_FP + V_SYNC));
    cur.act     = (hx < H_ACTIVE) && (vy < V_ACTIVE);
    cur.src     = SRC_BG;
    case (mode_q)
      MODE_ORIG: if (in_img0) begin
        rom_addr_c = addr0[ADDR_W-1:0];
        cur.src    = SRC_ROM;
      end
      MODE_PROC: if (in_img0) begin
        dmem_addr_c = addr0[ADDR_W-1:0];
        cur.src     = SRC_DMEM;
      end
      MODE_SIDE: begin
        if (in_img0) begin
          rom_addr_c = addr0[ADDR_W-1:0];
          cur.src    = SRC_ROM;
        end else if (in_img1) begin
          dmem_addr_c = addr1[ADDR_W-1:0];
          cur.src     = SRC_DMEM;
        end
      end
      default: ;
    endcase
  end

  // Addresses hold their last in-region value while the beam is elsewhere.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      rom_hold  <= '0;
      dmem_hold <= '0;
    end else begin
      rom_hold  <= rom_addr_c;
      dmem_hold <= dmem_addr_c;
    end
  end

  // Button synchroniser, edge counting into pending_mode, frame-boundary load.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      btn_s1        <= 1'b0;
      btn_s2        <= 1'b0;
      btn_d         <= 1'b0;
      pending_mode  <= MODE_ORIG;
      mode_q        <= MODE_ORIG;
      frame_start_q <= 1'b0;
    end else begin
      btn_s1        <= boton_cursor;
      btn_s2        <= btn_s1;
      btn_d         <= btn_s2;
      frame_start_q <= h_last && v_last;
      if (btn_s2 && !btn_d) pending_mode <= next_mode(pending_mode);
      if (h_last && v_last) mode_q <= pending_mode;
    end
  end

  // Delay line that keeps timing and tag aligned with returning memory data.
  always_ff @(posedge clock_25) begin
    // NOTE: this short shift register is reset on purpose so outputs stay idle until it fills.
    if (reset) begin
      for (int i = 0; i < MEM_LAT; i++) dly[i] <= VID_IDLE;
    end else begin
      dly[0] <= cur;
      for (int i = 1; i < MEM_LAT; i++) dly[i] <= dly[i-1];
    end
  end

  assign last = dly[MEM_LAT-1];

  // Registered pins: sync, blank and colour picked by the delayed tag.
  always_ff @(posedge clock_25) begin
    if (reset) begin
      hsync_q   <= 1'b1;
      vsync_q   <= 1'b1;
      n_blank_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hsync_q   <= last.hs;
      vsync_q   <= last.vs;
      n_blank_q <= last.act;
      if (!last.act) begin
        rgb_q <= '0;
      end else begin
        case (last.src)
          SRC_ROM:  rgb_q <= bus.rom_data;
          SRC_DMEM: rgb_q <= {3{bus.dmem_data[7:0]}};
          default:  rgb_q <= BG_RGB;
        endcase
      end
    end
  end

  assign bus.rom_addr    = rom_addr_c;
  assign bus.dmem_addr   = dmem_addr_c;
  assign bus.red         = rgb_q[23:16];
  assign bus.green       = rgb_q[15:8];
  assign bus.blue        = rgb_q[7:0];
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.n_blank     = n_blank_q;
  assign bus.frame_start = frame_start_q;
  assign bus.mode        = mode_q;

endmodule

// File: tb/tb_vga_dual_view.sv
// Directed bench for vga_dual_view: two scaled-down instances, one with
// MEM_LAT=2 (A) and one with MEM_LAT=1 and a wider active area (B).
module tb_vga_dual_view;

  // A: H 40+4+6+6=56, V 30+2+2+3=37. B: H 50+4+6+6=66, same V.
  localparam int HT_A = 56;
  localparam int VT_A = 37;
  localparam int HT_B = 66;
  localparam int VT_B = 37;
  localparam int FA   = HT_A * VT_A;
  localparam int FB   = HT_B * VT_B;

  logic clk   = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic btn_a = 1'b0;
  logic btn_b = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;
  int ha = 0, va = 0, hb = 0, vb = 0;
  int hs_a, vs_a, nb_a, hs_b, vs_b, nb_b, k, r;
  logic [23:0] line_buf [HT_B];

  always #20 clk = ~clk;

  vga_dual_view_if #(.ADDR_W(18)) bus_a ();
  vga_dual_view_if #(.ADDR_W(18)) bus_b ();

  vga_dual_view #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(8), .IMG_H(8), .X0(2), .Y0(7), .GAP(4),
    .ADDR_W(18), .MEM_LAT(2), .BG_RGB(24'h202020)
  ) dut_a (
    .clock_25(clk), .reset(rst_a), .boton_cursor(btn_a), .bus(bus_a)
  );

  vga_dual_view #(
    .H_ACTIVE(50), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(8), .IMG_H(8), .X0(2), .Y0(7), .GAP(4),
    .ADDR_W(18), .MEM_LAT(1), .BG_RGB(24'h202020)
  ) dut_b (
    .clock_25(clk), .reset(rst_b), .boton_cursor(btn_b), .bus(bus_b)
  );

  // Memory models: ROM returns addr+1, dmem returns {FFFFFF, addr[7:0]}.
  logic [17:0] ra_p [2];
  logic [17:0] da_p [2];
  logic [17:0] rb_p;
  logic [17:0] db_p;
  always @(posedge clk) begin
    ra_p[0] <= bus_a.rom_addr;
    ra_p[1] <= ra_p[0];
    da_p[0] <= bus_a.dmem_addr;
    da_p[1] <= da_p[0];
    rb_p    <= bus_b.rom_addr;
    db_p    <= bus_b.dmem_addr;
  end
  assign bus_a.rom_data  = 24'(ra_p[1]) + 24'd1;
  assign bus_a.dmem_data = {24'hFFFFFF, da_p[1][7:0]};
  assign bus_b.rom_data  = 24'(rb_p) + 24'd1;
  assign bus_b.dmem_data = {24'hFFFFFF, db_p[7:0]};

  // Reference beam position of each instance.
  always @(posedge clk) begin
    if (rst_a) begin
      ha <= 0; va <= 0;
    end else if (ha == HT_A - 1) begin
      ha <= 0; va <= (va == VT_A - 1) ? 0 : va + 1;
    end else begin
      ha <= ha + 1;
    end
    if (rst_b) begin
      hb <= 0; vb <= 0;
    end else if (hb == HT_B - 1) begin
      hb <= 0; vb <= (vb == VT_B - 1) ? 0 : vb + 1;
    end else begin
      hb <= hb + 1;
    end
  end

  logic [23:0] pix_a, pix_b;
  assign pix_a = {bus_a.red, bus_a.green, bus_a.blue};
  assign pix_b = {bus_b.red, bus_b.green, bus_b.blue};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic bit at_pos(input bit sel, input int h, input int v);
    return sel ? (hb == h && vb == v) : (ha == h && va == v);
  endfunction

  task automatic wait_pos(input bit sel, input int h, input int v);
    int n;
    n = 0;
    while (!at_pos(sel, h, v) && n < 6000) begin
      tick();
      n++;
    end
    if (n >= 6000) begin
      n_checks++;
      $error("FAIL wait_pos: position (%0d,%0d) on dut %0d not reached", h, v, sel);
    end
  endtask

  // Record one line of output colour, already realigned to beam position.
  task automatic capture(input bit sel, input int v, input int lat, input int ht);
    wait_pos(sel, 0, v);
    repeat (lat + 1) tick();
    for (int x = 0; x < ht; x++) begin
      line_buf[x] = sel ? pix_b : pix_a;
      tick();
    end
  endtask

  task automatic press();
    btn_a = 1'b1;
    repeat (4) tick();
    btn_a = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    repeat (3) tick();

    // Reset state
    check("rst_a_hsync", bus_a.hsync, 1'b1);
    check("rst_a_vsync", bus_a.vsync, 1'b1);
    check("rst_a_nblank", bus_a.n_blank, 1'b0);
    check("rst_a_rgb", pix_a, 24'h000000);
    check("rst_a_mode", bus_a.mode, 2'd0);
    check("rst_a_rom_addr", bus_a.rom_addr, 18'd0);
    check("rst_a_dmem_addr", bus_a.dmem_addr, 18'd0);
    check("rst_a_frame_start", bus_a.frame_start, 1'b0);
    check("rst_b_hsync", bus_b.hsync, 1'b1);
    check("rst_b_nblank", bus_b.n_blank, 1'b0);
    check("rst_b_rgb", pix_b, 24'h000000);
    check("rst_b_mode", bus_b.mode, 2'd0);

    // Two frames of timing on both instances
    rst_a = 1'b0;
    rst_b = 1'b0;
    hs_a = 0; vs_a = 0; nb_a = 0; hs_b = 0; vs_b = 0; nb_b = 0;
    for (int i = 0; i < 2 * FB; i++) begin
      if (i < 2 * FA) begin
        hs_a += int'(!bus_a.hsync);
        vs_a += int'(!bus_a.vsync);
        nb_a += int'(bus_a.n_blank);
      end
      hs_b += int'(!bus_b.hsync);
      vs_b += int'(!bus_b.vsync);
      nb_b += int'(bus_b.n_blank);
      tick();
    end
    check("a_hsync_low_cycles", hs_a, 6 * 37 * 2);
    check("a_vsync_low_cycles", vs_a, 2 * 56 * 2);
    check("a_nblank_cycles", nb_a, 40 * 30 * 2);
    check("b_hsync_low_cycles", hs_b, 6 * 37 * 2);
    check("b_vsync_low_cycles", vs_b, 2 * 66 * 2);
    check("b_nblank_cycles", nb_b, 50 * 30 * 2);

    // frame_start to first n_blank: MEM_LAT+1
    check("b_frame_start", bus_b.frame_start, 1'b1);
    k = 0;
    while (!bus_b.n_blank && k < 200) begin tick(); k++; end
    check("b_nblank_latency", k, 2);
    wait_pos(1'b0, 0, 0);
    check("a_frame_start", bus_a.frame_start, 1'b1);
    k = 0;
    while (!bus_a.n_blank && k < 200) begin tick(); k++; end
    check("a_nblank_latency", k, 3);

    // Mode 0 on A: image corners, address hold, 3-cycle colour latency
    wait_pos(1'b0, 2, 7);
    check("a_m0_rom_addr_first", bus_a.rom_addr, 18'd0);
    check("a_m0_dmem_addr_idle", bus_a.dmem_addr, 18'd0);
    repeat (3) tick();
    check("a_m0_rgb_first", pix_a, 24'h000001);
    wait_pos(1'b0, 9, 14);
    check("a_m0_rom_addr_last", bus_a.rom_addr, 18'd63);
    tick();
    check("a_m0_rom_addr_hold", bus_a.rom_addr, 18'd63);
    repeat (2) tick();
    check("a_m0_rgb_last", pix_a, 24'h000040);

    // Mode 0 on B (MEM_LAT=1, 50 visible)
    capture(1'b1, 8, 1, HT_B);
    check("b_x1_bg", line_buf[1], 24'h202020);
    check("b_x2_rom", line_buf[2], 24'h000009);
    check("b_x9_rom", line_buf[9], 24'h000010);
    check("b_x10_bg", line_buf[10], 24'h202020);
    check("b_x49_bg", line_buf[49], 24'h202020);
    check("b_x50_blank", line_buf[50], 24'h000000);
    wait_pos(1'b1, 9, 14);
    check("b_rom_addr_last", bus_b.rom_addr, 18'd63);

    // Two presses mid-frame: mode holds, then becomes 2 at wrap
    wait_pos(1'b0, 0, 3);
    press();
    press();
    check("a_mode_mid_frame", bus_a.mode, 2'd0);
    wait_pos(1'b0, HT_A - 1, VT_A - 1);
    check("a_mode_last_cycle", bus_a.mode, 2'd0);
    tick();
    check("a_mode_after_wrap", bus_a.mode, 2'd2);

    // Side-by-side line at ly=1
    capture(1'b0, 8, 2, HT_A);
    check("a_m2_x1_bg", line_buf[1], 24'h202020);
    check("a_m2_x2_rom", line_buf[2], 24'h000009);
    check("a_m2_x9_rom", line_buf[9], 24'h000010);
    check("a_m2_x10_gap", line_buf[10], 24'h202020);
    check("a_m2_x13_gap", line_buf[13], 24'h202020);
    check("a_m2_x14_dmem", line_buf[14], 24'h080808);
    check("a_m2_x21_dmem", line_buf[21], 24'h0f0f0f);
    check("a_m2_x22_bg", line_buf[22], 24'h202020);
    check("a_m2_x39_bg", line_buf[39], 24'h202020);
    check("a_m2_x40_blank", line_buf[40], 24'h000000);

    // Two more presses: 2 -> 0 -> 1 at next wrap
    wait_pos(1'b0, 0, 20);
    press();
    press();
    check("a_mode2_mid_frame", bus_a.mode, 2'd2);
    wait_pos(1'b0, 0, 0);
    check("a_mode1_after_wrap", bus_a.mode, 2'd1);

    // Mode 1: dmem gray, upper word bits ignored, rom address held
    wait_pos(1'b0, 7, 7);
    check("a_m1_dmem_addr", bus_a.dmem_addr, 18'd5);
    check("a_m1_rom_addr_hold", bus_a.rom_addr, 18'd63);
    repeat (3) tick();
    check("a_m1_rgb_gray", pix_a, 24'h050505);
    wait_pos(1'b0, 14, 8);
    check("a_m1_dmem_addr_hold", bus_a.dmem_addr, 18'd15);
    repeat (3) tick();
    check("a_m1_no_second_image", pix_a, 24'h202020);

    // Held button: exactly one increment over three frames
    wait_pos(1'b0, 0, 10);
    btn_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      wait_pos(1'b0, 0, 0);
      check($sformatf("a_hold_frame%0d", f), bus_a.mode, 2'd2);
      tick();
    end
    btn_a = 1'b0;
    wait_pos(1'b0, 0, 0);
    check("a_hold_release", bus_a.mode, 2'd2);

    // Reset in the middle of a frame
    wait_pos(1'b0, 20, 10);
    rst_a = 1'b1;
    tick();
    check("a_mid_rst_rom_addr", bus_a.rom_addr, 18'd0);
    check("a_mid_rst_dmem_addr", bus_a.dmem_addr, 18'd0);
    check("a_mid_rst_mode", bus_a.mode, 2'd0);
    check("a_mid_rst_hsync", bus_a.hsync, 1'b1);
    check("a_mid_rst_vsync", bus_a.vsync, 1'b1);
    check("a_mid_rst_nblank", bus_a.n_blank, 1'b0);
    check("a_mid_rst_rgb", pix_a, 24'h000000);
    rst_a = 1'b0;
    k = 0;
    while (bus_a.hsync && k < 300) begin tick(); k++; end
    check("a_resume_hsync_fall", k, 44 + 3);
    r = 0;
    while (!bus_a.hsync && r < 100) begin tick(); r++; end
    check("a_resume_hsync_width", r, 6);
    wait_pos(1'b0, 0, 0);
    check("a_resume_mode_cleared", bus_a.mode, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
